// File: rtl/axis_uart_rx_fifo.sv
// UART receiver feeding an AXI-Stream FIFO; a packet closes on an idle gap of IDLE_BITS bit-times.
// Define UART_RX_PARITY_EN for 8E1-style framing (one even-parity bit after the data bits).
module axis_uart_rx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic             m_axis_last,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int IDLE_LIMIT   = IDLE_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(IDLE_LIMIT + 1);
  localparam int BW           = $clog2(WIDTH + 1);
  localparam int AW           = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic [TW-1:0] IDLE_END = TW'(IDLE_LIMIT - 1);
  localparam logic [TW-1:0] IDLE_ONE = TW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_UNIT = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    even_parity = ^d;
  endfunction
`endif

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  rx_state_t        state_r;
  rx_state_t        state_s;
  logic [CW-1:0]    baud_cnt_r;
  logic [BW-1:0]    bit_idx_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] byte_r;
  logic             byte_vld_r;
  logic             frame_err_r;
  logic             overflow_r;
  logic             par_ok_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_r;
  logic             parity_err_r;
`endif

  logic             fall_s;
  logic             half_s;
  logic             bit_end_s;
  logic             last_bit_s;

  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0] last_mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    prev_ptr_s;
  logic [AW:0]      count_r;
  logic             open_r;
  logic [TW-1:0]    idle_cnt_r;
  logic             head_closed_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             timeout_s;

  assign fall_s     = rx_prev_r & ~rx_sync_r;
  assign half_s     = (baud_cnt_r == HALF_END);
  assign bit_end_s  = (baud_cnt_r == BIT_END);
  assign last_bit_s = (bit_idx_r == LAST_IDX);

`ifdef UART_RX_PARITY_EN
  assign par_ok_s   = ~par_bad_r;
  assign parity_err = parity_err_r;
`else
  assign par_ok_s   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Synchronizer resets low so a line held low at release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b0;
      rx_sync_r <= 1'b0;
      rx_prev_r <= 1'b0;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Receiver next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_s = ST_START;
        else        state_s = ST_IDLE;
      end
      ST_START: begin
        if (half_s) begin
          if (rx_sync_r) state_s = ST_IDLE;
          else           state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
          state_s = ST_PARITY;
`else
          state_s = ST_STOP;
`endif
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) state_s = ST_STOP;
        else           state_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (bit_end_s) state_s = ST_IDLE;
        else           state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bit timing, data shifting and per-frame verdicts (push request or error pulse).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_r   <= {CW{1'b0}};
      bit_idx_r    <= {BW{1'b0}};
      shift_r      <= {WIDTH{1'b0}};
      byte_r       <= {WIDTH{1'b0}};
      byte_vld_r   <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      byte_vld_r   <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= {CW{1'b0}};
          bit_idx_r  <= {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
          par_bad_r  <= 1'b0;
`endif
        end
        ST_START: begin
          if (half_s) baud_cnt_r <= {CW{1'b0}};
          else        baud_cnt_r <= baud_cnt_r + CNT_ONE;
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CW{1'b0}};
            shift_r    <= {rx_sync_r, shift_r[WIDTH-1:1]};
            bit_idx_r  <= bit_idx_r + IDX_ONE;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            baud_cnt_r   <= {CW{1'b0}};
            par_bad_r    <= (rx_sync_r != even_parity(shift_r));
            parity_err_r <= (rx_sync_r != even_parity(shift_r));
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CW{1'b0}};
            if (!rx_sync_r) begin
              frame_err_r <= 1'b1;
            end else if (par_ok_s) begin
              byte_vld_r <= 1'b1;
              byte_r     <= shift_r;
            end else begin
              byte_vld_r <= 1'b0;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        default: baud_cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // The newest entry stays hidden while open, so the head is visible only once closed.
  assign head_closed_s = (count_r > CNT_UNIT) || ((count_r == CNT_UNIT) && !open_r);
  assign full_s        = (count_r == CNT_FULL);
  assign pop_s         = head_closed_s & m_axis_ready;
  assign push_s        = byte_vld_r & (~full_s | pop_s);
  assign drop_s        = byte_vld_r & full_s & ~pop_s;
  assign timeout_s     = open_r & ~push_s & (state_r == ST_IDLE) & (idle_cnt_r == IDLE_END);
  assign prev_ptr_s    = wr_ptr_r - PTR_ONE;

  assign m_axis_valid  = head_closed_s;
  assign m_axis_data   = head_closed_s ? data_mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign m_axis_last   = head_closed_s ? last_mem_r[rd_ptr_r] : 1'b0;
  assign overflow      = overflow_r;
  assign frame_err     = frame_err_r;

  // FIFO pointers, occupancy, open-entry tracking and the idle-gap timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW + 1){1'b0}};
      open_r     <= 1'b0;
      idle_cnt_r <= {TW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
      if (push_s) begin
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
        open_r     <= 1'b1;
        idle_cnt_r <= {TW{1'b0}};
      end else if (timeout_s) begin
        open_r     <= 1'b0;
        idle_cnt_r <= {TW{1'b0}};
      end else if (open_r && (state_r == ST_IDLE)) begin
        idle_cnt_r <= idle_cnt_r + IDLE_ONE;
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else       rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + (push_s ? CNT_UNIT : CNT_ZERO) - (pop_s ? CNT_UNIT : CNT_ZERO);
    end
  end

  // Entry storage; a push closes the previous entry implicitly since it is written with last=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) data_mem_r[i] <= {WIDTH{1'b0}};
      last_mem_r <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= byte_r;
        last_mem_r[wr_ptr_r] <= 1'b0;
      end else if (timeout_s) begin
        last_mem_r[prev_ptr_s] <= 1'b1;
      end else begin
        last_mem_r <= last_mem_r;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Self-checking bench for axis_uart_rx_fifo: serial frames in, AXI-Stream beats compared with a queue model.
module tb_axis_uart_rx_fifo;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int CLK_RATE  = 1600000;
  localparam int BAUD      = 100000;
  localparam int IDLE_BITS = 20;
  localparam int CPB       = CLK_RATE / BAUD;
  localparam int LIMIT     = IDLE_BITS * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             uart_rx = 1'b1;
  logic             m_axis_ready = 1'b0;
  logic [WIDTH-1:0] m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic             overflow;
  logic             frame_err;
  logic             parity_err;

  int vectors = 0;
  int miscompares = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int unstable_cnt = 0;
  logic       hold_v = 1'b0;
  logic [8:0] hold_beat = 9'd0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic       rand_run = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip_g = 1'b0;
`endif

  axis_uart_rx_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_RATE(CLK_RATE), .BAUD(BAUD), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last), .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Passive monitor: counts pulses, collects accepted beats, watches hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (hold_v && (!m_axis_valid || ({m_axis_last, m_axis_data} != hold_beat))) unstable_cnt++;
      if (m_axis_valid && m_axis_ready) got_q.push_back({m_axis_last, m_axis_data});
      hold_v = m_axis_valid && !m_axis_ready;
      hold_beat = {m_axis_last, m_axis_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < WIDTH; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ par_flip_g;
    tick(CPB);
`endif
    uart_rx = stop_v;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    ovf_cnt = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    unstable_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    uart_rx = 1'b1;
    m_axis_ready = 1'b0;
    tick(5);
    vectors++; if (m_axis_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", m_axis_valid); end
    vectors++; if (m_axis_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %0b expected 0", m_axis_last); end
    vectors++; if (m_axis_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %0h expected 0", m_axis_data); end
    vectors++; if ({overflow, frame_err, parity_err} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b expected 000", {overflow, frame_err, parity_err}); end
    rst = 1'b1;
    tick(4 * CPB);
    vectors++; if (m_axis_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %0b expected 0", m_axis_valid); end
  endtask

  task automatic test_single();
    int cyc;
    clear_mon();
    m_axis_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    cyc = 0;
    while (!m_axis_valid && cyc < 3 * LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc < (IDLE_BITS - 1) * CPB || cyc > (IDLE_BITS + 1) * CPB) begin
      miscompares++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", cyc, (IDLE_BITS - 1) * CPB, (IDLE_BITS + 1) * CPB);
    end
    tick(4);
    exp_q.push_back({1'b1, 8'hA5});
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    m_axis_ready = 1'b1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    tick(2 * CPB);
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL b2b_before_timeout: got %0d beats expected 2", got_q.size()); end
    tick(LIMIT + 3 * CPB);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    m_axis_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1);
    vectors++; if (ovf_cnt != 10 - DEPTH) begin miscompares++; $display("FAIL ovf_pulses: got %0d expected %0d", ovf_cnt, 10 - DEPTH); end
    tick(LIMIT + 4 * CPB);
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL ovf_no_pop: got %0d beats expected 0", got_q.size()); end
    m_axis_ready = 1'b1;
    tick(DEPTH + 8);
    for (int i = 0; i < 10; i++) if (i < DEPTH) exp_q.push_back({(i == DEPTH - 1), 8'(i)});
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovf_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (unstable_cnt != 0) begin miscompares++; $display("FAIL ovf_hold_stable: got %0d changes expected 0", unstable_cnt); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    m_axis_ready = 1'b1;
    send_frame(8'h5A, 1'b0);
    tick(2 * CPB);
    send_frame(8'h3C, 1'b1);
    tick(LIMIT + 3 * CPB);
    exp_q.push_back({1'b1, 8'h3C});
    vectors++; if (ferr_cnt != 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ferr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ferr_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_parity();
    clear_mon();
    m_axis_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip_g = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip_g = 1'b0;
    tick(LIMIT + 3 * CPB);
    vectors++; if (perr_cnt != 1) begin miscompares++; $display("FAIL perr_pulses: got %0d expected 1", perr_cnt); end
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL perr_no_push: got %0d beats expected 0", got_q.size()); end
`endif
    send_frame(8'h07, 1'b1);
    tick(LIMIT + 3 * CPB);
    exp_q.push_back({1'b1, 8'h07});
`ifndef UART_RX_PARITY_EN
    vectors++; if (perr_cnt != 0) begin miscompares++; $display("FAIL perr_tied: got %0d pulses expected 0", perr_cnt); end
`endif
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL par_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL par_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    clear_mon();
    m_axis_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    tick(LIMIT + 3 * CPB);
    vectors++; if ({m_axis_valid, m_axis_last, m_axis_data} !== {1'b1, 1'b1, 8'h81}) begin
      miscompares++; $display("FAIL prereset_head: got %b/%b/%h expected 1/1/81", m_axis_valid, m_axis_last, m_axis_data);
    end
    d = 8'h55;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = d[3];
    tick(CPB / 2);
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    vectors++; if ({m_axis_valid, m_axis_last, m_axis_data} !== 10'd0) begin
      miscompares++; $display("FAIL midreset_outputs: got %b/%b/%h expected 0/0/00", m_axis_valid, m_axis_last, m_axis_data);
    end
    vectors++; if ({overflow, frame_err, parity_err} !== 3'b000) begin miscompares++; $display("FAIL midreset_pulses: got %b expected 000", {overflow, frame_err, parity_err}); end
    tick(3 * CPB);
    rst = 1'b1;
    m_axis_ready = 1'b1;
    tick(LIMIT + 4 * CPB);
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL midreset_no_partial: got %0d beats expected 0", got_q.size()); end
    send_frame(8'hC3, 1'b1);
    tick(LIMIT + 3 * CPB);
    exp_q.push_back({1'b1, 8'hC3});
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       long_gap;
    clear_mon();
    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          m_axis_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      long_gap = ($urandom_range(0, 2) == 0) || (i == 5);
      send_frame(d, 1'b1);
      exp_q.push_back({long_gap, d});
      if (long_gap) tick(LIMIT + 3 * CPB);
      else          tick($urandom_range(1, 4 * CPB));
    end
    rand_run = 1'b0;
    tick(2);
    m_axis_ready = 1'b1;
    tick(10);
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (unstable_cnt != 0) begin miscompares++; $display("FAIL rand_hold_stable: got %0d changes expected 0", unstable_cnt); end
    vectors++; if (ovf_cnt != 0) begin miscompares++; $display("FAIL rand_overflow: got %0d pulses expected 0", ovf_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_frame_err();
    test_parity();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_uart_rx_fifo.md
AXIS_UART_RX_FIFO -- requirements
Module: axis_uart_rx_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per UART frame and the m_axis_data width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter CLK_RATE, default 50000000, clock frequency in Hz.
REQ-004 SHALL have parameter BAUD, default 115200; CLKS_PER_BIT = CLK_RATE/BAUD (integer divide, 434 at defaults).
REQ-005 SHALL have parameter IDLE_BITS, default 20, the idle line time in bit-times that closes a packet.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port uart_rx, input, 1, serial line, idle high, asynchronous to clk.
REQ-009 SHALL have port m_axis_data, output, WIDTH, the head byte.
REQ-010 SHALL have port m_axis_valid, output, 1, head byte presented.
REQ-011 SHALL have port m_axis_ready, input, 1, sink accepts.
REQ-012 SHALL have port m_axis_last, output, 1, the head byte ends a packet.
REQ-013 SHALL have port overflow, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-015 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-016 SHALL pass uart_rx through a two-flop synchronizer before any use.
REQ-017 SHALL implement receiver states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL move IDLE->START on a synchronized falling edge, then resample at CLKS_PER_BIT/2; low->DATA, high->IDLE with no pulse (glitch).
REQ-019 SHALL sample WIDTH data bits LSB first, each CLKS_PER_BIT after the previous sample, then go to PARITY if enabled, else STOP.
REQ-020 SHALL sample the stop bit, return to IDLE in the same cycle, and be ready for a new start edge on the next cycle.
REQ-021 SHALL push the byte one cycle after a high stop sample; a low stop sample SHALL discard the byte and pulse frame_err.
REQ-022 SHALL, when the FIFO is full and no pop happens that cycle, drop the byte, pulse overflow and leave FIFO contents unchanged.
REQ-023 SHALL accept a push in a cycle with a simultaneous pop when full; the count SHALL be unchanged.
REQ-024 SHALL pop exactly on m_axis_valid && m_axis_ready; m_axis_data and m_axis_last SHALL stay stable while valid is high and ready is low.
REQ-025 SHALL keep the newest entry hidden (it is "open") until it becomes closed.
REQ-026 SHALL close the newest entry when a later byte is pushed (entry last=0), or when IDLE_BITS*CLKS_PER_BIT cycles pass after its push with the receiver in IDLE (entry last=1).
REQ-027 SHALL drive m_axis_valid = head entry closed; m_axis_last = the stored last flag of the head.
REQ-028 SHALL restart the idle timer on every push; a START glitch SHALL NOT restart it.
REQ-029 SHALL let a frame_err or parity_err byte neither push nor restart the idle timer.

Reset
REQ-030 SHALL on rst low immediately force: receiver IDLE, FIFO empty, timer cleared, m_axis_valid=0, m_axis_last=0, m_axis_data=0, overflow=0, frame_err=0, parity_err=0.
REQ-031 SHALL abandon a frame in progress when reset asserts mid-frame; after release, wait for a fresh falling edge; a partial frame SHALL never be pushed.

Configuration
REQ-032 SHALL, with macro UART_RX_PARITY_EN defined, expect one even-parity bit after the data bits; on mismatch, pulse parity_err and discard the byte (stop bit still sampled, frame_err reported independently).
REQ-033 SHALL, without UART_RX_PARITY_EN, omit the PARITY state (8N1 framing) and tie parity_err to 0.

Verification
REQ-034 Single byte 0xA5, ready=1 -> valid high after 20*434 idle cycles after push; data 0xA5, last=1, one beat.
REQ-035 Back-to-back 0x11,0x22,0x33 -> 0x11 last=0, 0x22 last=0, 0x33 last=1 only after idle timeout.
REQ-036 Ready=0, ten bytes 0x00..0x09, DEPTH=8 -> overflow pulses twice; drain yields 0x00..0x07, last only on 0x07.
REQ-037 Stop bit forced low on 0x5A -> frame_err pulses once, nothing pushed; next byte 0x3C is received normally.
REQ-038 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 (wrong) -> parity_err pulses once, no push; correct parity 1 -> 0x07 delivered.
REQ-039 rst low during the 4th data bit -> all outputs 0; a byte 0xC3 sent after release is delivered intact, last=1.
